// File: rtl/pipeline_pkg.sv
// Shared widths and control-bundle bit positions for the EX/MEM pipeline stage.
package pipeline_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DST_W  = 4;
    localparam int DEF_CTRL_W = 5;
    localparam int DEF_FLAG_W = 3;

    // Bit positions inside the control bundle.
    localparam int MEMWRITE_BIT = 0;
    localparam int REGW_BIT     = 1;
    localparam int MEMTOREG_BIT = 2;
    localparam int PCTOREG_BIT  = 3;
    localparam int HALT_BIT     = 4;

endpackage

// File: rtl/pipe_slot.sv
// One payload register set with a load enable and synchronous clear.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Payload register: clears on reset, captures only when loaded, else holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {W{1'b0}};
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pipeline_stage.sv
// EX/MEM pipeline register with a two-entry (main + skid) buffer, flush, and
// forwarding-hit detection for the consumer's source registers.
module pipeline_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W   = pipeline_pkg::DEF_DATA_W,
    parameter int DST_W    = pipeline_pkg::DEF_DST_W,
    parameter int CTRL_W   = pipeline_pkg::DEF_CTRL_W,
    parameter int FLAG_W   = pipeline_pkg::DEF_FLAG_W,
    parameter int REGW_BIT = pipeline_pkg::REGW_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [FLAG_W-1:0] in_flags,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_store,
    input  logic [DST_W-1:0]  in_dst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [FLAG_W-1:0] out_flags,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_store,
    output logic [DST_W-1:0]  out_dst,
    input  logic [DST_W-1:0]  src_a,
    input  logic [DST_W-1:0]  src_b,
    output logic              fwd_a,
    output logic              fwd_b
);

    localparam int PAY_W = CTRL_W + FLAG_W + 2 * DATA_W + DST_W;

    logic              main_valid_r;
    logic              skid_valid_r;
    logic              main_valid_nxt_s;
    logic              skid_valid_nxt_s;
    logic              main_load_s;
    logic              skid_load_s;
    logic              accept_s;
    logic              drain_s;
    logic              main_open_s;
    logic [PAY_W-1:0]  in_pay_s;
    logic [PAY_W-1:0]  main_d_s;
    logic [PAY_W-1:0]  main_q_s;
    logic [PAY_W-1:0]  skid_q_s;
    logic [CTRL_W-1:0] main_ctrl_s;

    assign in_pay_s    = {in_ctrl, in_flags, in_data, in_store, in_dst};
    // Ready looks only at the skid slot so upstream never sees a path from out_ready.
    assign in_ready    = ~skid_valid_r & ~rst;
    assign accept_s    = in_valid & in_ready;
    assign drain_s     = main_valid_r & out_ready;
    assign main_open_s = ~main_valid_r | drain_s;

    // Slot steering: main refills from skid first to preserve order; skid only
    // absorbs an input when main is occupied and stalled.
    always_comb begin
        main_load_s      = 1'b0;
        skid_load_s      = 1'b0;
        main_d_s         = in_pay_s;
        main_valid_nxt_s = main_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (flush) begin
            main_valid_nxt_s = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else if (main_open_s) begin
            if (skid_valid_r) begin
                main_load_s      = 1'b1;
                main_d_s         = skid_q_s;
                main_valid_nxt_s = 1'b1;
                if (accept_s) begin
                    skid_load_s      = 1'b1;
                    skid_valid_nxt_s = 1'b1;
                end else begin
                    skid_valid_nxt_s = 1'b0;
                end
            end else if (accept_s) begin
                main_load_s      = 1'b1;
                main_valid_nxt_s = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else begin
                main_valid_nxt_s = 1'b0;
                skid_valid_nxt_s = 1'b0;
            end
        end else begin
            main_valid_nxt_s = 1'b1;
            if (accept_s) begin
                skid_load_s      = 1'b1;
                skid_valid_nxt_s = 1'b1;
            end else begin
                skid_valid_nxt_s = skid_valid_r;
            end
        end
    end

    // Slot valid bits: reset dominates flush, which the steering logic already applies.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else begin
            main_valid_r <= main_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
        end
    end

    pipe_slot #(.W(PAY_W)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load_s),
        .d    (main_d_s),
        .q    (main_q_s)
    );

    pipe_slot #(.W(PAY_W)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load_s),
        .d    (in_pay_s),
        .q    (skid_q_s)
    );

    assign {main_ctrl_s, out_flags, out_data, out_store, out_dst} = main_q_s;
    assign out_valid = main_valid_r;
    // A bubble must never carry MemWrite/RegWrite downstream.
    assign out_ctrl  = main_valid_r ? main_ctrl_s : {CTRL_W{1'b0}};

    assign fwd_a = out_valid & out_ctrl[REGW_BIT] & (out_dst == src_a) & (out_dst != {DST_W{1'b0}});
    assign fwd_b = out_valid & out_ctrl[REGW_BIT] & (out_dst == src_b) & (out_dst != {DST_W{1'b0}});

endmodule

// File: tb/tb_pipeline_stage.sv
// Scoreboard bench for pipeline_stage: a FIFO-of-payloads model (capacity two)
// predicts handshakes and output order; directed scenarios plus random traffic.
module tb_pipeline_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [4:0]  in_ctrl, out_ctrl;
    logic [2:0]  in_flags, out_flags;
    logic [15:0] in_data, in_store, out_data, out_store;
    logic [3:0]  in_dst, out_dst, src_a, src_b;
    logic        fwd_a, fwd_b;

    typedef struct packed {
        logic [4:0]  ctrl;
        logic [2:0]  flags;
        logic [15:0] data;
        logic [15:0] store;
        logic [3:0]  dst;
    } pay_t;

    pay_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   n_drain = 0;
    logic rst_d = 1'b0;

    always #5 clk = ~clk;

    pipeline_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_flags(in_flags), .in_data(in_data),
        .in_store(in_store), .in_dst(in_dst), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_flags(out_flags), .out_data(out_data), .out_store(out_store),
        .out_dst(out_dst), .src_a(src_a), .src_b(src_b),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Output monitor: compares the DUT against the head of the model queue.
    always @(negedge clk) begin
        pay_t h;
        logic ea, eb;
        if (rst) begin
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            if (rst_d) begin
                chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
                chk("rst_out_ctrl", {27'd0, out_ctrl}, 32'd0);
                chk("rst_out_flags", {29'd0, out_flags}, 32'd0);
                chk("rst_out_data", {16'd0, out_data}, 32'd0);
                chk("rst_out_store", {16'd0, out_store}, 32'd0);
                chk("rst_out_dst", {28'd0, out_dst}, 32'd0);
                chk("rst_fwd", {30'd0, fwd_a, fwd_b}, 32'd0);
            end
        end else begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
            chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2)});
            if (q.size() != 0) begin
                h  = q[0];
                ea = h.ctrl[1] && (h.dst == src_a) && (h.dst != 4'd0);
                eb = h.ctrl[1] && (h.dst == src_b) && (h.dst != 4'd0);
                chk("out_ctrl", {27'd0, out_ctrl}, {27'd0, h.ctrl});
                chk("out_flags", {29'd0, out_flags}, {29'd0, h.flags});
                chk("out_data", {16'd0, out_data}, {16'd0, h.data});
                chk("out_store", {16'd0, out_store}, {16'd0, h.store});
                chk("out_dst", {28'd0, out_dst}, {28'd0, h.dst});
                chk("fwd_a", {31'd0, fwd_a}, {31'd0, ea});
                chk("fwd_b", {31'd0, fwd_b}, {31'd0, eb});
                if (out_ready) begin
                    void'(q.pop_front());
                    n_drain++;
                end
            end else begin
                chk("bubble_ctrl", {27'd0, out_ctrl}, 32'd0);
                chk("bubble_fwd", {30'd0, fwd_a, fwd_b}, 32'd0);
            end
        end
        rst_d <= rst;
    end

    // Input monitor: records accepted payloads; flush and reset empty the model.
    always @(negedge clk) begin
        #1;
        if (rst || flush) begin
            q.delete();
        end else if (in_valid && in_ready) begin
            q.push_back({in_ctrl, in_flags, in_data, in_store, in_dst});
        end
    end

    task automatic drive(input logic v, input logic [4:0] c, input logic [15:0] d,
                         input logic [3:0] dst, input logic ordy, input logic fl,
                         input logic r);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        in_dst    = dst;
        in_flags  = 3'($urandom);
        in_store  = 16'($urandom);
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_step(input logic r, input int flush_pct);
        src_a = 4'($urandom_range(0, 3));
        src_b = 4'($urandom_range(0, 3));
        drive(1'($urandom_range(0, 1)), 5'($urandom), 16'($urandom),
              4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 99) < flush_pct), r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        src_a = 4'd0;
        src_b = 4'd0;
        repeat (3) drive(1'b0, 5'd0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 5'd0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Passthrough
        drive(1'b1, 5'h03, 16'h1234, 4'd5, 1'b1, 1'b0, 1'b0);
        chk("pt_valid", {31'd0, out_valid}, 32'd1);
        chk("pt_data", {16'd0, out_data}, 32'h1234);
        chk("pt_ctrl", {27'd0, out_ctrl}, 32'h03);
        drive(1'b0, 5'd0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0);

        // Backpressure
        drive(1'b1, 5'h01, 16'h0001, 4'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'h01, 16'h0002, 4'd2, 1'b0, 1'b0, 1'b0);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_a", {16'd0, out_data}, 32'h0001);
        drive(1'b0, 5'd0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("bp_stable_a", {16'd0, out_data}, 32'h0001);
        drive(1'b0, 5'd0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("bp_out_b", {16'd0, out_data}, 32'h0002);
        drive(1'b0, 5'd0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("bp_empty", {31'd0, out_valid}, 32'd0);
        chk("bp_ready_again", {31'd0, in_ready}, 32'd1);

        // Flush with both slots full and an input offered
        drive(1'b1, 5'h1f, 16'h00a1, 4'd7, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'h1f, 16'h00a2, 4'd7, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'h1f, 16'h00a3, 4'd7, 1'b0, 1'b1, 1'b0);
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_ctrl", {27'd0, out_ctrl}, 32'd0);
        chk("fl_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) drive(1'b0, 5'd0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("fl_quiet", {31'd0, out_valid}, 32'd0);

        // Forwarding
        drive(1'b1, 5'h02, 16'h0033, 4'd3, 1'b0, 1'b0, 1'b0);
        src_a = 4'd3;
        src_b = 4'd4;
        #1;
        chk("fwd_hit_a", {31'd0, fwd_a}, 32'd1);
        chk("fwd_miss_b", {31'd0, fwd_b}, 32'd0);
        drive(1'b0, 5'd0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 5'h02, 16'h0044, 4'd0, 1'b0, 1'b0, 1'b0);
        src_a = 4'd0;
        #1;
        chk("fwd_dst0", {31'd0, fwd_a}, 32'd0);
        drive(1'b0, 5'd0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0);

        // Streaming
        drive(1'b0, 5'd0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        s0 = n_drain;
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 5'($urandom), 16'(i + 16'h0100), 4'($urandom), 1'b1, 1'b0, 1'b0);
            chk("st_in_ready", {31'd0, in_ready}, 32'd1);
        end
        drive(1'b0, 5'd0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("st_count", 32'(n_drain - s0), 32'd64);

        // Random traffic with reset mid-stream
        for (int i = 0; i < 100; i++) rnd_step((i == 50) || (i == 51), 0);
        // Random traffic with occasional flush
        for (int i = 0; i < 200; i++) rnd_step(1'b0, 6);

        repeat (4) drive(1'b0, 5'd0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
